// File: rtl/shift_add_acc_ctrl_if.sv
// Handshake/result bundle for the shift-and-add multiplier controller.
// The master issues operands and start; the slave reports step select, status and product.
interface shift_add_acc_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic                   add_sel;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, mcand, mplier,
        input  add_sel, busy, done, product
    );

    modport slave (
        input  start, mcand, mplier,
        output add_sel, busy, done, product
    );
endinterface

// File: rtl/shift_add_acc_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller (IDLE -> CALC -> DONE).
// Optional macro SAA_EARLY_TERM_EN ends CALC once the remaining multiplier bits are zero.
module shift_add_acc_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_add_acc_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH:0]     acc;
    logic [WIDTH-1:0]     mcand_q;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum_upper;
    logic [2*WIDTH:0]     step_acc;
    logic                 last_step;
    logic [2*WIDTH-1:0]   final_product;

    // One step: conditional add into {carry, upper}, then shift the whole register right.
    always_comb begin
        sum_upper = acc[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        if (acc[0]) begin
            step_acc = {sum_upper, acc[WIDTH-1:0]} >> 1;
        end else begin
            step_acc = acc >> 1;
        end
    end

`ifdef SAA_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;

    // After this step the unshifted multiplier bits are lower[cnt-1:1]; if all zero the
    // remaining steps are pure shifts, which are folded into the product load.
    always_comb begin
        rem_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rem_mask[i] = ((i + 1) < int'(cnt));
        end
        last_step     = (cnt == CW'(1)) || (((acc[WIDTH-1:0] >> 1) & rem_mask) == '0);
        final_product = (2*WIDTH)'(step_acc >> (cnt - CW'(1)));
    end
`else
    always_comb begin
        last_step     = (cnt == CW'(1));
        final_product = step_acc[2*WIDTH-1:0];
    end
`endif

    // Controller FSM; add_sel is registered as the LSB the next CALC cycle will see.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mcand_q     <= '0;
            cnt         <= '0;
            bus.add_sel <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done    <= 1'b0;
                    bus.add_sel <= 1'b0;
                    if (bus.start) begin
                        acc         <= {{(WIDTH+1){1'b0}}, bus.mplier};
                        mcand_q     <= bus.mcand;
                        cnt         <= CW'(WIDTH);
                        bus.add_sel <= bus.mplier[0];
                        bus.busy    <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    if (last_step) begin
                        cnt         <= '0;
                        bus.product <= final_product;
                        bus.done    <= 1'b1;
                        bus.add_sel <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt         <= cnt - CW'(1);
                        bus.add_sel <= step_acc[0];
                    end
                end
                DONE: begin
                    bus.done    <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.add_sel <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_acc_ctrl.sv
// Directed self-checking bench for shift_add_acc_ctrl at WIDTH = 4.
// Expected latencies follow SAA_EARLY_TERM_EN when it is defined for the build.
module tb_shift_add_acc_ctrl;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    shift_add_acc_ctrl_if #(.WIDTH(4)) bus ();

    shift_add_acc_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SAA_EARLY_TERM_EN
    localparam int LAT_13X11 = 5;
    localparam int LAT_15X15 = 5;
    localparam int LAT_9X0   = 2;
    localparam int LAT_7X6   = 4;
    localparam int LAT_2X3   = 3;
    localparam int LAT_3X5   = 4;
    localparam int LAT_10X2  = 3;
`else
    localparam int LAT_13X11 = 5;
    localparam int LAT_15X15 = 5;
    localparam int LAT_9X0   = 5;
    localparam int LAT_7X6   = 5;
    localparam int LAT_2X3   = 5;
    localparam int LAT_3X5   = 5;
    localparam int LAT_10X2  = 5;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advances until done is seen; n = edges taken, or -1 if the bound expires.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mcand = '0;
        bus.mplier = '0;
        #3;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %0b expected 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %0b expected 0", bus.done); end
        vectors++;
        if (bus.add_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_add_sel got %0b expected 0", bus.add_sel); end
        vectors++;
        if (bus.product !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_product got %0d expected 0", bus.product); end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_mult();
        logic [3:0] sel_exp;
        int         lat;
        sel_exp = 4'b1011;
        issue(4'd13, 4'd11);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.add_sel !== sel_exp[k]) begin
                miscompares++;
                $display("[TB] FAIL basic_add_sel[%0d] got %0b expected %0b", k, bus.add_sel, sel_exp[k]);
            end
            vectors++;
            if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_busy[%0d] got %0b expected 1", k, bus.busy); end
            if (k < 3) step();
        end
        wait_done(lat);
        lat = (lat < 0) ? -1 : lat + 4;
        vectors++;
        if (lat !== LAT_13X11) begin miscompares++; $display("[TB] FAIL basic_latency got %0d expected %0d", lat, LAT_13X11); end
        vectors++;
        if (bus.product !== 8'd143) begin miscompares++; $display("[TB] FAIL basic_product got %0d expected 143", bus.product); end
        step();
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_pulse got %0b expected 0", bus.done); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_idle_busy got %0b expected 0", bus.busy); end
        vectors++;
        if (bus.product !== 8'd143) begin miscompares++; $display("[TB] FAIL basic_product_hold got %0d expected 143", bus.product); end
    endtask

    task automatic test_carry();
        int lat;
        issue(4'd15, 4'd15);
        wait_done(lat);
        bus.start = 1'b0;
        vectors++;
        if (lat !== LAT_15X15) begin miscompares++; $display("[TB] FAIL carry_latency got %0d expected %0d", lat, LAT_15X15); end
        vectors++;
        if (bus.product !== 8'd225) begin miscompares++; $display("[TB] FAIL carry_product got %0d expected 225", bus.product); end
        step();
    endtask

    task automatic test_zero_mplier();
        int lat;
        issue(4'd9, 4'd0);
        step();
        bus.start = 1'b0;
        vectors++;
        if (bus.add_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_add_sel got %0b expected 0", bus.add_sel); end
        if (bus.done === 1'b1) begin
            lat = 1;
        end else begin
            wait_done(lat);
            lat = (lat < 0) ? -1 : lat + 1;
        end
        vectors++;
        if (lat !== LAT_9X0) begin miscompares++; $display("[TB] FAIL zero_latency got %0d expected %0d", lat, LAT_9X0); end
        vectors++;
        if (bus.product !== 8'd0) begin miscompares++; $display("[TB] FAIL zero_product got %0d expected 0", bus.product); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(4'd7, 4'd6);
        step();
        bus.mcand  = 4'd2;
        bus.mplier = 4'd3;
        wait_done(lat);
        lat = (lat < 0) ? -1 : lat + 1;
        vectors++;
        if (lat !== LAT_7X6) begin miscompares++; $display("[TB] FAIL b2b_first_latency got %0d expected %0d", lat, LAT_7X6); end
        vectors++;
        if (bus.product !== 8'd42) begin miscompares++; $display("[TB] FAIL b2b_first_product got %0d expected 42", bus.product); end
        step();
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_gap got busy %0b expected 0", bus.busy); end
        vectors++;
        if (bus.product !== 8'd42) begin miscompares++; $display("[TB] FAIL b2b_hold got %0d expected 42", bus.product); end
        step();
        vectors++;
        if (bus.product !== 8'd42) begin miscompares++; $display("[TB] FAIL b2b_hold_calc got %0d expected 42", bus.product); end
        wait_done(lat);
        lat = (lat < 0) ? -1 : lat + 1;
        bus.start = 1'b0;
        vectors++;
        if (lat !== LAT_2X3) begin miscompares++; $display("[TB] FAIL b2b_second_latency got %0d expected %0d", lat, LAT_2X3); end
        vectors++;
        if (bus.product !== 8'd6) begin miscompares++; $display("[TB] FAIL b2b_second_product got %0d expected 6", bus.product); end
        step();
    endtask

    task automatic test_reset_mid_calc();
        int dones;
        int lat;
        issue(4'd13, 4'd11);
        step();
        bus.start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %0b expected 0", bus.busy); end
        vectors++;
        if (bus.product !== 8'd0) begin miscompares++; $display("[TB] FAIL abort_product got %0d expected 0", bus.product); end
        vectors++;
        if (bus.add_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_add_sel got %0b expected 0", bus.add_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0d pulses expected 0", dones); end
        issue(4'd3, 4'd5);
        wait_done(lat);
        bus.start = 1'b0;
        vectors++;
        if (lat !== LAT_3X5) begin miscompares++; $display("[TB] FAIL post_reset_latency got %0d expected %0d", lat, LAT_3X5); end
        vectors++;
        if (bus.product !== 8'd15) begin miscompares++; $display("[TB] FAIL post_reset_product got %0d expected 15", bus.product); end
        step();
    endtask

    task automatic test_early_term();
        int lat;
        issue(4'd10, 4'd2);
        wait_done(lat);
        bus.start = 1'b0;
        vectors++;
        if (lat !== LAT_10X2) begin miscompares++; $display("[TB] FAIL early_latency got %0d expected %0d", lat, LAT_10X2); end
        vectors++;
        if (bus.product !== 8'd20) begin miscompares++; $display("[TB] FAIL early_product got %0d expected 20", bus.product); end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_mult();
        test_carry();
        test_zero_mplier();
        test_back_to_back();
        test_reset_mid_calc();
        test_early_term();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_add_acc_ctrl.md
SHIFT_ADD_ACC_CTRL -- requirements
Module: shift_add_acc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits; product width is 2*WIDTH (default 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port mcand  input  WIDTH  multiplicand, unsigned; captured on accepted start.
REQ-006 SHALL have port mplier  input  WIDTH  multiplier, unsigned; captured on accepted start.
REQ-007 SHALL have port add_sel  output  1  accumulator-path select: 1 = add step this cycle, 0 = shift-only.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; product valid in the same cycle.
REQ-010 SHALL have port product  output  2*WIDTH  result register.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after final step, DONE->IDLE unconditionally next cycle.
REQ-012 SHALL accept start only in IDLE; start in CALC or DONE is ignored without effect on operands, counter or product.
REQ-013 On accepted start SHALL clear the WIDTH+1-bit upper accumulator (carry + high half), load mplier into the lower half, capture mcand, and load the step counter with WIDTH.
REQ-014 Each CALC cycle SHALL drive add_sel = current lower-half LSB; if 1, upper = upper + mcand (WIDTH+1-bit sum, carry kept); then the {carry, upper, lower} register SHALL shift right one bit, with the counter decremented.
REQ-015 SHALL leave CALC when the counter reaches zero; fixed latency start-accept to done = WIDTH+1 cycles (5 at default).
REQ-016 SHALL load product with the 2*WIDTH accumulator value on the CALC->DONE transition and hold it until the next DONE; done high exactly one cycle, in DONE state.
REQ-017 busy SHALL be high in CALC and DONE, low in IDLE; add_sel SHALL be 0 outside CALC.
REQ-018 Carry out of the add SHALL never be lost; 2*WIDTH bits always hold the exact product (max 15*15 = 225 fits 8 bits).
REQ-019 start asserted in the DONE cycle SHALL be ignored; a new multiply needs start in IDLE (back-to-back issue rate one per WIDTH+2 cycles).

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, busy 0, done 0, add_sel 0, product 0, accumulator 0, counter 0, regardless of clock.
REQ-021 Reset asserted mid-CALC SHALL abort the operation with no done pulse; product SHALL read 0 after reset.
REQ-022 After rst_n deasserts, the first rising edge with start high SHALL be accepted normally.

Configuration
REQ-023 Macro SAA_EARLY_TERM_EN SHALL, when defined, end CALC early when the remaining unshifted multiplier bits are all zero, performing the remaining shifts in the DONE-load step so product is still exact; latency = (index of highest set mplier bit + 1) + 1 cycles, minimum 2 (mplier = 0).
REQ-024 Without SAA_EARLY_TERM_EN latency SHALL be fixed at WIDTH+1 cycles for every operand value.

Verification
REQ-025 Reset, then mcand=4'd13, mplier=4'd11, start pulse -> add_sel sequence 1,1,0,1; done 5 cycles after start; product=8'd143.
REQ-026 mcand=4'd15, mplier=4'd15 -> product=8'd225, carry path exercised, no truncation.
REQ-027 mcand=4'd9, mplier=4'd0 -> product=8'd0; done at cycle 5 (macro off) or cycle 2 (SAA_EARLY_TERM_EN on).
REQ-028 start held high continuously with 7*6 then changed operands -> second op starts only in IDLE after done; product 42 held until next done.
REQ-029 rst_n pulsed low during third CALC cycle -> outputs 0 asynchronously, no done; subsequent 3*5 yields 15.
REQ-030 With SAA_EARLY_TERM_EN, mcand=4'd10, mplier=4'd2 -> done 3 cycles after start, product=8'd20.
